psram_arbiter: RTL

- Single-clock arbiter that shares the one PSRAM controller command port between two requesters:
  - the display line-fetch reader (read bursts);
  - the SPI-side framebuffer writer (write bursts).
- Sits between both requesters and the PSRAM HS controller, in the PSRAM clock domain.
- Enforces the controller's command spacing and calibration gating.
- Reads have priority, with a bounded-starvation guarantee for writes.

---
 rtl/psram_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/psram_arbiter.sv
// Shares the PSRAM controller command port between the display reader and the framebuffer writer.
// Reads win by default; a write is forced through after MAX_RD_STREAK consecutive reads.
module psram_arbiter #(
    parameter int ADDR_W        = 21,
    parameter int BURST_BEATS   = 4,
    parameter int CMD_INTERVAL  = 18,
    parameter int MAX_RD_STREAK = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mem_init_calib,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_gnt,
    output logic [63:0]       o_rd_data,
    output logic              o_rd_data_valid,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [63:0]       i_wr_data,
    input  logic [7:0]        i_wr_mask,
    output logic              o_wr_data_rd,
    output logic              o_wr_gnt,
    output logic              o_mem_cmd,
    output logic              o_mem_cmd_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [63:0]       o_mem_wr_data,
    output logic [7:0]        o_mem_data_mask,
    input  logic [63:0]       i_mem_rd_data,
    input  logic              i_mem_rd_data_valid,
    output logic              o_req_overrun
);

    localparam int CNT_W    = $clog2(CMD_INTERVAL + 1);
    localparam int BEAT_W   = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam int STREAK_W = $clog2(MAX_RD_STREAK + 1);

    typedef enum logic [2:0] {
        WAIT_CAL,
        READY,
        RD_CMD,
        WR_CMD,
        GAP
    } state_t;

    state_t              state, state_nxt;
    logic                rd_pend, wr_pend;
    logic [ADDR_W-1:0]   rd_addr_q, wr_addr_q;
    logic [STREAK_W-1:0] streak;
    logic [CNT_W-1:0]    since_cmd;
    logic [BEAT_W-1:0]   beat;
    logic                overrun;

    logic rd_issue, wr_first, wr_last, gap_done, streak_full;

    assign rd_issue    = (state == RD_CMD);
    assign wr_first    = (state == WR_CMD) && (beat == '0);
    assign wr_last     = (state == WR_CMD) && (beat == BEAT_W'(BURST_BEATS - 1));
    assign streak_full = (streak == STREAK_W'(MAX_RD_STREAK));
    // READY always burns one cycle, so GAP releases two cycles before the next legal strobe.
    assign gap_done    = (since_cmd >= CNT_W'(CMD_INTERVAL - 2));

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            WAIT_CAL: if (i_mem_init_calib) state_nxt = READY;
            READY: begin
                if (!i_mem_init_calib)                         state_nxt = WAIT_CAL;
                else if (rd_pend && !(wr_pend && streak_full)) state_nxt = RD_CMD;
                else if (wr_pend)                              state_nxt = WR_CMD;
            end
            RD_CMD:   state_nxt = GAP;
            WR_CMD:   if (wr_last) state_nxt = GAP;
            GAP:      if (gap_done) state_nxt = i_mem_init_calib ? READY : WAIT_CAL;
            default:  state_nxt = WAIT_CAL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= WAIT_CAL;
            rd_pend   <= 1'b0;
            wr_pend   <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            streak    <= '0;
            since_cmd <= '0;
            beat      <= '0;
            overrun   <= 1'b0;
        end else begin
            state <= state_nxt;

            // A pulse landing in the grant cycle re-arms the flag instead of counting as overrun.
            rd_pend <= i_rd_req | (rd_pend & ~rd_issue);
            wr_pend <= i_wr_req | (wr_pend & ~wr_first);
            if (i_rd_req && (!rd_pend || rd_issue)) rd_addr_q <= i_rd_addr;
            if (i_wr_req && (!wr_pend || wr_first)) wr_addr_q <= i_wr_addr;
            if ((i_rd_req && rd_pend && !rd_issue) || (i_wr_req && wr_pend && !wr_first))
                overrun <= 1'b1;

            if (rd_issue)
                streak <= !wr_pend ? '0 : (streak_full ? streak : streak + STREAK_W'(1));
            else if (wr_first)
                streak <= '0;

            if (rd_issue || wr_first)
                since_cmd <= CNT_W'(1);
            else if (since_cmd != CNT_W'(CMD_INTERVAL))
                since_cmd <= since_cmd + CNT_W'(1);

            if (state == WR_CMD)
                beat <= wr_last ? '0 : beat + BEAT_W'(1);
        end
    end

    assign o_mem_cmd_en    = rd_issue | wr_first;
    assign o_mem_cmd       = wr_first;
    assign o_rd_gnt        = rd_issue;
    assign o_wr_gnt        = wr_first;
    assign o_mem_addr      = rd_issue ? rd_addr_q : (wr_first ? wr_addr_q : '0);
    assign o_wr_data_rd    = (state == WR_CMD);
    assign o_mem_wr_data   = i_wr_data;
    assign o_mem_data_mask = i_wr_mask;
    assign o_rd_data       = i_mem_rd_data;
    assign o_rd_data_valid = i_mem_rd_data_valid;
    assign o_req_overrun   = overrun;

endmodule
